// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Brief    : Shared types and constants for the data-side line responder.
// Revision : 1.0
// ============================================================================
package rv32i_types;

    localparam int DLINE_OFFSET_BITS = 5;
    localparam int DLINE_TAG_BITS    = 32 - DLINE_OFFSET_BITS;
    localparam int DLINE_BITS        = 8 << DLINE_OFFSET_BITS;

    typedef logic [DLINE_BITS-1:0] dline_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WB   = 2'd2,
        FILL = 2'd3
    } dline_state_t;

endpackage
`default_nettype wire

// File: rtl/dline_array.sv
`default_nettype none
// ============================================================================
// Module   : dline_array
// Brief    : Single write-back line store with word read-mux, byte-masked
//            word write and full-line load.
// Revision : 1.0
// ============================================================================
module dline_array
    import rv32i_types::*;
#(
    parameter int OFFSET_BITS = DLINE_OFFSET_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OFFSET_BITS-3:0]      i_word_idx,
    input  logic                        i_wr_en,
    input  logic [3:0]                  i_wmask,
    input  logic [31:0]                 i_wdata,
    input  logic                        i_load_en,
    input  logic [(8<<OFFSET_BITS)-1:0] i_load_data,
    input  logic [31-OFFSET_BITS:0]     i_load_tag,
    input  logic                        i_clr_dirty,
    output logic [31:0]                 o_rd_word,
    output logic [(8<<OFFSET_BITS)-1:0] o_line,
    output logic [31-OFFSET_BITS:0]     o_tag,
    output logic                        o_valid,
    output logic                        o_dirty
);

    logic [(8<<OFFSET_BITS)-1:0] r_data;
    logic [31-OFFSET_BITS:0]     r_tag;
    logic                        r_valid;
    logic                        r_dirty;
    logic [31:0]                 w_merged;

    assign o_rd_word = r_data[{i_word_idx, 5'b00000} +: 32];
    assign o_line    = r_data;
    assign o_tag     = r_tag;
    assign o_valid   = r_valid;
    assign o_dirty   = r_dirty;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign w_merged[8*b +: 8] = i_wmask[b] ? i_wdata[8*b +: 8] : o_rd_word[8*b +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_dirty <= 1'b0;
        end else if (i_load_en) begin
            r_data  <= i_load_data;
            r_tag   <= i_load_tag;
            r_valid <= 1'b1;
            r_dirty <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_data[{i_word_idx, 5'b00000} +: 32] <= w_merged;
                // An all-zero mask changes nothing, so the line stays clean.
                if (|i_wmask) begin
                    r_dirty <= 1'b1;
                end
            end
            if (i_clr_dirty) begin
                r_dirty <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dline_responder.sv
`default_nettype none
// ============================================================================
// Module   : dline_responder
// Brief    : MEM-stage word responder backed by one write-back line buffer.
// Revision : 1.0
// ============================================================================
module dline_responder
    import rv32i_types::*;
#(
    parameter int OFFSET_BITS = DLINE_OFFSET_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        read_b,
    input  logic                        write,
    input  logic [3:0]                  wmask,
    input  logic [31:0]                 address_b,
    input  logic [31:0]                 wdata,
    output logic                        resp_b,
    output logic [31:0]                 rdata_b,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_address,
    output logic [(8<<OFFSET_BITS)-1:0] pmem_wdata,
    input  logic [(8<<OFFSET_BITS)-1:0] pmem_rdata,
    input  logic                        pmem_resp
);

    dline_state_t                r_state;
    dline_state_t                w_next;
    logic [31-OFFSET_BITS:0]     w_addr_tag;
    logic [OFFSET_BITS-3:0]      w_word_idx;
    logic [31:0]                 w_rd_word;
    logic [(8<<OFFSET_BITS)-1:0] w_line;
    logic [31-OFFSET_BITS:0]     w_tag;
    logic                        w_valid;
    logic                        w_dirty;
    logic                        w_hit;
    logic                        w_req;
    logic                        w_wr_en;
    logic                        w_load_en;
    logic                        w_clr_dirty;
    logic                        w_unused_addr;

    assign w_addr_tag    = address_b[31:OFFSET_BITS];
    assign w_word_idx    = address_b[OFFSET_BITS-1:2];
    assign w_unused_addr = ^address_b[1:0];
    assign w_hit         = w_valid && (w_tag == w_addr_tag);
    assign w_req         = read_b | write;

    dline_array #(
        .OFFSET_BITS (OFFSET_BITS)
    ) u_array (
        .clk         (clk),
        .rst_n       (reset),
        .i_word_idx  (w_word_idx),
        .i_wr_en     (w_wr_en),
        .i_wmask     (wmask),
        .i_wdata     (wdata),
        .i_load_en   (w_load_en),
        .i_load_data (pmem_rdata),
        .i_load_tag  (w_addr_tag),
        .i_clr_dirty (w_clr_dirty),
        .o_rd_word   (w_rd_word),
        .o_line      (w_line),
        .o_tag       (w_tag),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode from state alone, so an asynchronous reset clears them at once.
    always_comb begin
        w_next       = r_state;
        resp_b       = 1'b0;
        rdata_b      = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_wr_en      = 1'b0;
        w_load_en    = 1'b0;
        w_clr_dirty  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit)        w_next = RESP;
                    else if (w_dirty) w_next = WB;
                    else              w_next = FILL;
                end
            end
            RESP: begin
                resp_b  = 1'b1;
                rdata_b = w_rd_word;
                w_wr_en = write;
                w_next  = IDLE;
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {w_tag, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = w_line;
                if (pmem_resp) begin
                    w_clr_dirty = 1'b1;
                    w_next      = w_req ? FILL : IDLE;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_addr_tag, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    w_load_en = 1'b1;
                    w_next    = w_req ? RESP : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dline_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dline_responder
// Brief    : Self-checking bench for dline_responder with a line-memory model.
// Revision : 1.0
// ============================================================================
module tb_dline_responder;

    logic         clk;
    logic         reset;
    logic         read_b;
    logic         write;
    logic [3:0]   wmask;
    logic [31:0]  address_b;
    logic [31:0]  wdata;
    logic         resp_b;
    logic [31:0]  rdata_b;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    dline_responder dut (
        .clk          (clk),
        .reset        (reset),
        .read_b       (read_b),
        .write        (write),
        .wmask        (wmask),
        .address_b    (address_b),
        .wdata        (wdata),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;
    int rd_cycles = 0;
    int mem_lat = 3;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } log_t;
    log_t log_q[$];

    logic [255:0] mem  [bit [26:0]];
    logic [31:0]  arch [bit [29:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] h;
        if (a[31:2] == 30'h11) return 32'hDEAD_BEEF;
        h = {a[31:2], 2'b00} * 32'h9E37_79B1;
        return h ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] t);
        logic [255:0] l;
        if (mem.exists(t)) return mem[t];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({t, w[2:0], 2'b00});
        return l;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        if (arch.exists(a[31:2])) return arch[a[31:2]];
        return init_word({a[31:2], 2'b00});
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Physical memory: responds to a held strobe after mem_lat extra cycles.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
            end else if (pmem_read || pmem_write) begin
                wait_cnt++;
                if (wait_cnt > mem_lat) begin
                    if (pmem_write) begin
                        mem[pmem_address[31:5]] = pmem_wdata;
                        log_q.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = mem_line(pmem_address[31:5]);
                        log_q.push_back('{1'b0, pmem_address, pmem_rdata});
                    end
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    // Protocol monitor: strobe exclusivity, strobe hold, quiet outputs in reset.
    initial begin
        bit prev_rd, prev_wr, prev_resp;
        prev_rd = 0; prev_wr = 0; prev_resp = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (resp_b || pmem_read || pmem_write || pmem_address != 0 ||
                    pmem_wdata != 0 || rdata_b != 0) n_viol++;
                prev_rd = 0; prev_wr = 0; prev_resp = 0;
            end else begin
                if (pmem_read && pmem_write) n_viol++;
                if (resp_b && (pmem_read || pmem_write)) n_viol++;
                if (prev_rd && !pmem_read && !prev_resp) n_viol++;
                if (prev_wr && !pmem_write && !prev_resp) n_viol++;
                if (pmem_read) rd_cycles++;
                prev_rd = pmem_read; prev_wr = pmem_write; prev_resp = pmem_resp;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] wm,
                             output logic [31:0] rdata, output int lat, output bit got);
        read_b = rd; write = wr; address_b = a; wdata = wd; wmask = wm;
        lat = 0; got = 0; rdata = '0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (resp_b) begin
                got   = 1;
                rdata = rdata_b;
            end
        end
        // Hold the request through the RESP closing edge so a write merges.
        @(posedge clk); #1;
        read_b = 0; write = 0;
    endtask

    task automatic log_scan(output bit has_wb, output logic [31:0] wb_a, output logic [255:0] wb_d,
                            output bit has_fill, output logic [31:0] fill_a, output bit order_ok);
        has_wb = 0; wb_a = '0; wb_d = '0; has_fill = 0; fill_a = '0; order_ok = 1;
        foreach (log_q[i]) begin
            if (log_q[i].is_wr) begin
                has_wb = 1; wb_a = log_q[i].addr; wb_d = log_q[i].data;
                if (has_fill) order_ok = 0;
            end else begin
                has_fill = 1; fill_a = log_q[i].addr;
            end
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          exp_wb;
        logic [31:0] wb_addr;
        bit          exp_fill;
        logic [31:0] fill_addr;
    } vec_t;
    vec_t tbl [12];

    logic [31:0]  rdata, a, wd, wold, exp_rd;
    logic [3:0]   wm;
    logic [255:0] wb_d, last_wb, exp_line;
    logic [31:0]  wb_a, fill_a;
    logic [26:0]  model_tag;
    bit           model_valid, model_dirty, exp_hit;
    bit           got, has_wb, has_fill, order_ok, saw_resp, rd, wr;
    int           lat, guard, rd_snap, kind;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h44,   32'h0,         4'h0, 32'hDEAD_BEEF,     -1, 1'b0, 32'h0,  1'b1, 32'h40};
        tbl[1]  = '{1'b1, 1'b0, 32'h48,   32'h0,         4'h0, init_word(32'h48),  1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h44,   32'h1122_3344, 4'h5, 32'hDEAD_BEEF,      1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h44,   32'h0,         4'h0, 32'hDE22_BE44,      1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h48,   32'hFFFF_FFFF, 4'h0, init_word(32'h48),  1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h48,   32'h0,         4'h0, init_word(32'h48),  1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h1000, 32'h0,         4'h0, init_word(32'h1000),-1, 1'b1, 32'h40, 1'b1, 32'h1000};
        tbl[7]  = '{1'b1, 1'b0, 32'h40,   32'h0,         4'h0, init_word(32'h40), -1, 1'b0, 32'h0,  1'b1, 32'h40};
        tbl[8]  = '{1'b0, 1'b1, 32'h44,   32'hFFFF_FFFF, 4'h0, 32'hDE22_BE44,      1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'h0, init_word(32'h1004),-1, 1'b0, 32'h0,  1'b1, 32'h1000};
        tbl[10] = '{1'b1, 1'b1, 32'h100C, 32'hA5A5_A5A5, 4'hF, init_word(32'h100C), 1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h100C, 32'h0,         4'h0, 32'hA5A5_A5A5,      1, 1'b0, 32'h0,  1'b0, 32'h0};

        reset = 0; read_b = 0; write = 0; wmask = 0; address_b = 0; wdata = 0;
        last_wb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_b", resp_b, 0);
        chk("rst_pmem_rw", {pmem_read, pmem_write}, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        reset = 1;
        @(posedge clk); #1;
        chk("idle_outputs", {resp_b, pmem_read, pmem_write, rdata_b}, 0);

        // Directed table: cold read, hits, masked store, dirty eviction.
        mem_lat = 3;
        for (int i = 0; i < 12; i++) begin
            log_q.delete();
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].wm, rdata, lat, got);
            chk($sformatf("vec%0d_resp", i), got, 1);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            if (tbl[i].exp_lat >= 0) chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            log_scan(has_wb, wb_a, wb_d, has_fill, fill_a, order_ok);
            chk($sformatf("vec%0d_wb", i), has_wb, tbl[i].exp_wb);
            if (tbl[i].exp_wb) chk($sformatf("vec%0d_wb_addr", i), wb_a, tbl[i].wb_addr);
            chk($sformatf("vec%0d_fill", i), has_fill, tbl[i].exp_fill);
            if (tbl[i].exp_fill) chk($sformatf("vec%0d_fill_addr", i), fill_a, tbl[i].fill_addr);
            chk($sformatf("vec%0d_order", i), order_ok, 1);
            if (has_wb) last_wb = wb_d;
        end
        chk("evict_word1", last_wb[63:32], 32'hDE22_BE44);
        chk("evict_word2", last_wb[95:64], init_word(32'h48));

        // Request withdrawn during FILL (current line 0x1000 is dirty).
        log_q.delete();
        saw_resp = 0;
        read_b = 1; address_b = 32'h2004;
        guard = 0;
        while (!pmem_read && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            saw_resp |= resp_b;
        end
        chk("wdf_fill_strobe", pmem_read, 1);
        read_b = 0;
        repeat (20) begin
            @(posedge clk); #1;
            saw_resp |= resp_b;
        end
        chk("wdf_no_resp", saw_resp, 0);
        log_scan(has_wb, wb_a, wb_d, has_fill, fill_a, order_ok);
        chk("wdf_wb_addr", {has_wb, wb_a}, {1'b1, 32'h1000});
        chk("wdf_fill_addr", {has_fill, fill_a}, {1'b1, 32'h2000});
        log_q.delete();
        do_access(1, 0, 32'h2004, 0, 0, rdata, lat, got);
        chk("wdf_hit_lat", {got, lat}, {1'b1, 32'd1});
        chk("wdf_hit_rdata", rdata, init_word(32'h2004));

        // Request withdrawn during WB: write-back completes, no fill follows.
        do_access(0, 1, 32'h2008, 32'hCAFE_F00D, 4'hF, rdata, lat, got);
        chk("wdw_store_lat", {got, lat}, {1'b1, 32'd1});
        log_q.delete();
        rd_snap = rd_cycles;
        read_b = 1; address_b = 32'h3000;
        guard = 0;
        while (!pmem_write && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wdw_wb_strobe", pmem_write, 1);
        read_b = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("wdw_no_fill", rd_cycles - rd_snap, 0);
        log_scan(has_wb, wb_a, wb_d, has_fill, fill_a, order_ok);
        chk("wdw_wb_addr", {has_wb, has_fill, wb_a}, {1'b1, 1'b0, 32'h2000});
        chk("wdw_wb_word2", wb_d[95:64], 32'hCAFE_F00D);
        do_access(1, 0, 32'h2008, 0, 0, rdata, lat, got);
        chk("wdw_hit_lat", {got, lat}, {1'b1, 32'd1});
        chk("wdw_hit_rdata", rdata, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a write-back.
        do_access(0, 1, 32'h2008, 32'h0BAD_C0DE, 4'hF, rdata, lat, got);
        chk("rwb_store_resp", got, 1);
        log_q.delete();
        read_b = 1; address_b = 32'h3000;
        guard = 0;
        while (!pmem_write && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rwb_wb_strobe", pmem_write, 1);
        #2;
        reset = 0;
        #1;
        chk("rwb_async_drop", {pmem_write, pmem_read, resp_b, pmem_address}, 0);
        read_b = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1;
        log_q.delete();
        do_access(1, 0, 32'h2008, 0, 0, rdata, lat, got);
        chk("rwb_miss_resp", got, 1);
        chk("rwb_miss_slow", lat > 1, 1);
        log_scan(has_wb, wb_a, wb_d, has_fill, fill_a, order_ok);
        chk("rwb_fill_only", {has_wb, has_fill, fill_a}, {1'b0, 1'b1, 32'h2000});
        chk("rwb_rdata", rdata, 32'hCAFE_F00D);

        // Randomized traffic against an architectural memory + one-line model.
        model_valid = 1; model_tag = 27'(32'h2000 >> 5); model_dirty = 0;
        for (int k = 0; k < 250; k++) begin
            a = 32'h0000_8000 | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            rd = (kind != 2);
            wr = (kind >= 2);
            wd = $urandom;
            wm = 4'($urandom);
            mem_lat = $urandom_range(0, 4);
            exp_rd = arch_rd(a);
            exp_hit = model_valid && (model_tag == a[31:5]);
            log_q.delete();
            do_access(rd, wr, a, wd, wm, rdata, lat, got);
            chk($sformatf("rnd%0d_resp", k), got, 1);
            chk($sformatf("rnd%0d_rdata", k), rdata, exp_rd);
            log_scan(has_wb, wb_a, wb_d, has_fill, fill_a, order_ok);
            if (exp_hit) begin
                chk($sformatf("rnd%0d_hit_lat", k), lat, 1);
                chk($sformatf("rnd%0d_hit_quiet", k), log_q.size(), 0);
            end else begin
                chk($sformatf("rnd%0d_fill", k), {has_fill, fill_a}, {1'b1, a[31:5], 5'b0});
                chk($sformatf("rnd%0d_wb", k), has_wb, model_dirty);
                if (model_dirty) begin
                    for (int w = 0; w < 8; w++) exp_line[w*32 +: 32] = arch_rd({model_tag, w[2:0], 2'b00});
                    chk($sformatf("rnd%0d_wb_addr", k), wb_a, {model_tag, 5'b0});
                    chk($sformatf("rnd%0d_wb_data", k), wb_d, exp_line);
                    chk($sformatf("rnd%0d_order", k), order_ok, 1);
                end
                model_valid = 1; model_tag = a[31:5]; model_dirty = 0;
            end
            if (wr) begin
                wold = arch_rd(a);
                for (int b = 0; b < 4; b++) if (wm[b]) wold[8*b +: 8] = wd[8*b +: 8];
                arch[a[31:2]] = wold;
                if (wm != 0) model_dirty = 1;
            end
        end

        chk("protocol_violations", n_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dline_responder.md
Name: dline_responder

Overview:
- Data-side responder for the MEM-stage memory port: answers `read_b` / `write` word requests with a one-cycle `resp_b` pulse and `rdata_b`.
- Backed by a single 256-bit write-back line buffer, with a line-granular physical-memory port (`pmem_*`).
- Sits between the MEM stage and the memory arbiter.
- Hits complete in one cycle. Misses write back a dirty victim, then fill the line, before responding.

Parameters:
- OFFSET_BITS, 5, byte-offset width within a line (line = 2^OFFSET_BITS bytes = 256 bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- read_b  in  1  word read request; held stable until resp_b.
- write  in  1  word write request; held stable until resp_b.
- wmask  in  4  byte enables for write; bit i covers wdata[8i+7:8i].
- address_b  in  32  byte address; [1:0] ignored, [4:2] word select, [31:5] tag.
- wdata  in  32  store data, already lane-aligned.
- resp_b  out  1  one-cycle completion pulse.
- rdata_b  out  32  selected word; valid only while resp_b=1.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line write-back request; held until pmem_resp.
- pmem_address  out  32  line address, [4:0]=0.
- pmem_wdata  out  256  victim line data.
- pmem_rdata  in  256  fill data; valid when pmem_resp=1.
- pmem_resp  in  1  one-cycle completion pulse from memory.

Behaviour:
- Storage: data[255:0], tag[26:0], valid, dirty. Reset: valid=0, dirty=0, tag=0, data=0.
- Hit = valid && tag==address_b[31:5]. Request = read_b|write.
- States: IDLE, RESP, WB, FILL. Reset state IDLE.
- All outputs are 0 in reset and in IDLE.
- IDLE:
  - request & hit -> RESP.
  - request & miss & dirty -> WB.
  - request & miss & !dirty -> FILL.
  - no request -> IDLE.
- RESP:
  - resp_b=1 for exactly one cycle; rdata_b = data word address_b[4:2], pre-write value.
  - If write: merge wdata bytes per wmask into that word at the closing edge and set dirty=1. wmask=0 still responds, with no data change and dirty unchanged.
  - Next state IDLE.
  - Hit latency: request in cycle N -> resp_b in cycle N+1.
- WB:
  - pmem_write=1, pmem_address={tag,5'b0}, pmem_wdata=data.
  - On pmem_resp: dirty=0 -> FILL.
- FILL:
  - pmem_read=1, pmem_address={address_b[31:5],5'b0}.
  - On pmem_resp: data=pmem_rdata, tag=address_b[31:5], valid=1, dirty=0.
  - Then RESP if the request is still asserted, else IDLE.
- Request withdrawn during WB/FILL:
  - The pmem transaction in flight still completes; pmem strobes never drop before pmem_resp.
  - After WB completes, go to IDLE instead of FILL.
- read_b and write together: treated as a write. rdata_b returns the old word.
- resp_b and pmem_read/pmem_write are never asserted in the same cycle. pmem_read and pmem_write are mutually exclusive.
- Back-to-back hits: a request in the IDLE cycle following RESP is served normally, giving a 2-cycle throughput per access.
  - If the initiator holds a write across two RESPs because of an external stall, the second merge is identical and therefore harmless.
- Reset mid-operation (reset=0 at any time): state->IDLE, all outputs 0 asynchronously, valid=dirty=0. An outstanding pmem transaction is abandoned; the arbiter is reset by the same signal.
- pmem_resp outside WB/FILL is ignored.

Decomposition:
- rv32i_types gains:
  - dline_state_t enum {IDLE, RESP, WB, FILL}.
  - Constants DLINE_OFFSET_BITS=5, DLINE_TAG_BITS=27.
  - A typedef for the 256-bit line.
- Sub-module dline_array: holds data/tag/valid/dirty.
  - Provides a word read-mux and a byte-masked word write driven by wmask and the word index.
  - Provides a full-line load port.
- The FSM and hit compare stay in dline_responder.

Test Plan:
- Cold read: reset, read_b @0x0000_0044, memory returns line L (word1=0xDEAD_BEEF) after 3 cycles -> pmem_read with pmem_address=0x40 until pmem_resp, no pmem_write, then resp_b pulse with rdata_b=0xDEAD_BEEF.
- Hit latency: repeat read 0x48 -> resp_b exactly 1 cycle after request, no pmem activity, rdata_b = word2 of L.
- Masked store: write 0x44, wdata=0x1122_3344, wmask=4'b0101 -> next read of 0x44 returns 0xDE22_BE44 and dirty is set.
- Dirty eviction: read 0x0000_1000 -> pmem_write at 0x40 with modified line (word1=0xDE22_BE44), then pmem_read at 0x1000, then resp_b; the two strobes never overlap.
- Withdrawn request: drop read_b during FILL -> fill completes, line installed, no resp_b, state returns to IDLE.
- Async reset: assert reset=0 during WB -> pmem_write falls with no clock edge; afterwards a read of the old address misses (valid=0).
